// File: rtl/axi_rd_responder.sv
// AXI4 read-only subordinate answering 64-bit INCR bursts, one at a time, from a
// synchronous single-port memory whose read data arrives one cycle after mem_req_o.
module axi_rd_responder #(
   parameter int          AxiIdWidth = 4,
   parameter logic [63:0] AddrBase   = 64'h0001_0000,
   parameter int          MemWords   = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        ar_valid_i,
   output logic                        ar_ready_o,
   input  logic [63:0]                 ar_addr_i,
   input  logic [7:0]                  ar_len_i,
   input  logic [2:0]                  ar_size_i,
   input  logic [1:0]                  ar_burst_i,
   input  logic [AxiIdWidth-1:0]       ar_id_i,
   output logic                        r_valid_o,
   input  logic                        r_ready_i,
   output logic [63:0]                 r_data_o,
   output logic [AxiIdWidth-1:0]       r_id_o,
   output logic [1:0]                  r_resp_o,
   output logic                        r_last_o,
   output logic                        mem_req_o,
   output logic [$clog2(MemWords)-1:0] mem_addr_o,
   input  logic [63:0]                 mem_rdata_i,
   output logic                        busy_o
);

   localparam int          AW         = $clog2(MemWords);
   localparam logic [63:0] AddrLimit  = AddrBase + (64'(MemWords) << 3);
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;
   localparam logic [1:0]  RespDecErr = 2'b11;

   typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

   state_t        state;
   logic [7:0]    len_q;
   logic [7:0]    cnt_q;
   logic [AW-1:0] waddr_q;
   logic [63:0]   data_q;
   logic          fresh_q;
   logic [1:0]    ar_err;
   logic          ar_hs;
   logic          r_hs;

   always_comb begin
      ar_err = RespOkay;
      if (ar_burst_i != 2'b01 || ar_size_i != 3'b011) begin
         ar_err = RespSlvErr;
      end else if (ar_addr_i < AddrBase || ar_addr_i >= AddrLimit) begin
         ar_err = RespDecErr;
      end
   end

   assign ar_hs      = ar_valid_i && ar_ready_o;
   assign r_hs       = r_valid_o && r_ready_i;
   assign mem_addr_o = waddr_q;

   // The memory word is only on mem_rdata_i during the first RESP cycle of a beat;
   // after that the captured copy keeps r_data_o stable under backpressure.
   assign r_data_o = fresh_q ? mem_rdata_i : data_q;

   // NOTE: every register below is assigned with <= so all of them update from the
   // same pre-edge values; mixing in blocking assignments would make results order-dependent.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= IDLE;
         ar_ready_o <= 1'b0;
         r_valid_o  <= 1'b0;
         r_last_o   <= 1'b0;
         r_resp_o   <= RespOkay;
         r_id_o     <= '0;
         mem_req_o  <= 1'b0;
         busy_o     <= 1'b0;
         fresh_q    <= 1'b0;
         data_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         waddr_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               ar_ready_o <= 1'b1;
               if (ar_hs) begin
                  ar_ready_o <= 1'b0;
                  busy_o     <= 1'b1;
                  r_id_o     <= ar_id_i;
                  r_resp_o   <= ar_err;
                  len_q      <= ar_len_i;
                  cnt_q      <= '0;
                  waddr_q    <= AW'((ar_addr_i - AddrBase) >> 3);
                  data_q     <= '0;
                  if (ar_err == RespOkay) begin
                     mem_req_o <= 1'b1;
                     state     <= FETCH;
                  end else begin
                     r_valid_o <= 1'b1;
                     r_last_o  <= (ar_len_i == 8'd0);
                     state     <= RESP;
                  end
               end
            end

            FETCH: begin
               mem_req_o <= 1'b0;
               fresh_q   <= 1'b1;
               r_valid_o <= 1'b1;
               r_last_o  <= (cnt_q == len_q);
               state     <= RESP;
            end

            RESP: begin
               fresh_q <= 1'b0;
               if (fresh_q) begin
                  data_q <= mem_rdata_i;
               end
               if (r_hs) begin
                  if (cnt_q == len_q) begin
                     r_valid_o  <= 1'b0;
                     r_last_o   <= 1'b0;
                     busy_o     <= 1'b0;
                     ar_ready_o <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 8'd1;
                     waddr_q <= waddr_q + AW'(1);
                     if (r_resp_o == RespOkay) begin
                        r_valid_o <= 1'b0;
                        mem_req_o <= 1'b1;
                        state     <= FETCH;
                     end else begin
                        // Error beats carry no data, so the next one follows immediately.
                        r_last_o <= ((cnt_q + 8'd1) == len_q);
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
